seg_display_scheduler: RTL and testbench

Time-multiplexes the shared active-low SEG bus across the four AN digits of the board display. Holds a double-buffered four-character frame written by the FSMs over a valid/ready port. Inserts dead time between digits to suppress ghosting, and applies per-digit blinking. Sits between the top-level sequencing FSMs and the SEG/AN pins, replacing per-state single-digit AN/SEG muxes.

---
 rtl/seg_display_scheduler_pkg.sv | 50 +++++
 rtl/seg_display_scheduler_tick_gen.sv | 33 +++
 rtl/seg_display_scheduler.sv | 131 +++++++++++++
 tb/tb_seg_display_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scheduler_pkg.sv
// Shared FSM type, pin-level constants and ASCII-to-glyph decode for the
// four-digit multiplexed display.
package seg_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [7:0] CH_2 = 8'h32;
  localparam logic [7:0] CH_3 = 8'h33;
  localparam logic [7:0] CH_4 = 8'h34;
  localparam logic [7:0] CH_5 = 8'h35;
  localparam logic [7:0] CH_6 = 8'h36;
  localparam logic [7:0] CH_7 = 8'h37;
  localparam logic [7:0] CH_8 = 8'h38;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CH_C = 8'h63;
  localparam logic [7:0] CH_L = 8'h6C;
  localparam logic [7:0] CH_U = 8'h75;
  localparam logic [7:0] CH_R = 8'h72;

  // Segment order is {g,f,e,d,c,b,a}, active-low; unknown codes stay dark.
  function automatic logic [6:0] char_to_seg(input logic [7:0] c);
    logic [6:0] s;
    s = SEG_BLANK;
    case (c)
      CH_0: s = 7'h40;
      CH_1: s = 7'h79;
      CH_2: s = 7'h24;
      CH_3: s = 7'h30;
      CH_4: s = 7'h19;
      CH_5: s = 7'h12;
      CH_6: s = 7'h02;
      CH_7: s = 7'h78;
      CH_8: s = 7'h00;
      CH_9: s = 7'h10;
      CH_C: s = 7'h27;
      CH_L: s = 7'h4F;
      CH_U: s = 7'h63;
      CH_R: s = 7'h2F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_tick_gen.sv
// Free-running modulo-DIV counter with a one-cycle tick on its last count
// and a synchronous clear.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_clr,
  output logic                                   o_tick,
  output logic [$clog2(DIV > 1 ? DIV : 2)-1:0]   o_count
);

  localparam int W = $clog2(DIV > 1 ? DIV : 2);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tick  = w_last;
  assign o_count = r_cnt;

endmodule

// File: rtl/seg_display_scheduler.sv
// Scans a double-buffered four-character frame onto the shared SEG/AN pins
// with per-slot dead time and per-digit blinking.
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_HZ     = 2
) (
  input  logic       CLOCK_100MHz,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [1:0] WR_ADDR,
  input  logic [7:0] WR_CHAR,
  input  logic [3:0] BLINK_MASK,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       FRAME_DONE
);

  localparam int DIGIT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int BLINK_HALF   = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W       = $clog2(DIGIT_CYCLES > 1 ? DIGIT_CYCLES : 2);
  localparam int BLINK_W      = $clog2(BLINK_HALF > 1 ? BLINK_HALF : 2);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_digit;
  logic                r_dirty;
  logic                r_alive;
  logic                r_blink_on;
  logic [7:0]          r_shadow [4];
  logic [7:0]          r_active [4];
  logic [3:0]          r_an;
  logic [6:0]          r_seg;
  logic [3:0]          w_an_nxt;
  logic [6:0]          w_seg_nxt;

  logic                w_slot_tick;
  logic [SLOT_W-1:0]   w_slot_cnt;
  logic                w_blink_tick;
  logic [BLINK_W-1:0]  w_blink_cnt_unused;
  logic                w_frame_end;
  logic                w_commit;
  logic                w_wr_fire;

  tick_gen #(.DIV(DIGIT_CYCLES)) u_slot (
    .i_clk   (CLOCK_100MHz),
    .i_rst   (RESET),
    .i_clr   (!ENABLE || (r_state == ST_IDLE)),
    .o_tick  (w_slot_tick),
    .o_count (w_slot_cnt)
  );

  tick_gen #(.DIV(BLINK_HALF)) u_blink (
    .i_clk   (CLOCK_100MHz),
    .i_rst   (RESET),
    .i_clr   (1'b0),
    .o_tick  (w_blink_tick),
    .o_count (w_blink_cnt_unused)
  );

  // Commit slots are known a cycle ahead, so READY is withheld exactly there.
  assign w_frame_end = (r_state == ST_DRIVE) && (r_digit == 2'd3) && w_slot_tick;
  assign w_commit    = r_dirty && ((r_state == ST_IDLE) || w_frame_end);
  assign WR_READY    = r_alive && !w_commit;
  assign w_wr_fire   = WR_VALID && WR_READY;

  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = AN_OFF;
    w_seg_nxt   = SEG_BLANK;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_BLANK;
      ST_BLANK: if (w_slot_cnt == SLOT_W'(BLANK_CYCLES - 1)) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (w_slot_tick) w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!ENABLE) w_state_nxt = ST_IDLE;
    if (ENABLE && (r_state == ST_DRIVE)) begin
      w_seg_nxt = char_to_seg(r_active[r_digit]);
      if (r_blink_on || !BLINK_MASK[r_digit]) w_an_nxt[r_digit] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_100MHz or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_digit    <= 2'd0;
      r_alive    <= 1'b0;
      r_blink_on <= 1'b1;
      r_an       <= AN_OFF;
      r_seg      <= SEG_BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      if (w_blink_tick) r_blink_on <= !r_blink_on;
      if (!ENABLE || (r_state == ST_IDLE)) begin
        r_digit <= 2'd0;
      end else if ((r_state == ST_DRIVE) && w_slot_tick) begin
        r_digit <= r_digit + 2'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_100MHz or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= CH_SPACE;
        r_active[i] <= CH_SPACE;
      end
      r_dirty <= 1'b0;
    end else if (w_commit) begin
      r_active <= r_shadow;
      r_dirty  <= 1'b0;
    end else if (w_wr_fire) begin
      r_shadow[WR_ADDR] <= WR_CHAR;
      r_dirty           <= 1'b1;
    end
  end

  assign SEG        = r_seg;
  assign AN         = r_an;
  assign FRAME_DONE = w_frame_end;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench: a frame-level reference model predicts every cycle's pins,
// a negedge monitor compares them against the DUT.
module tb_seg_display_scheduler;

  localparam int DIGIT_CYC = 1000 / 100;
  localparam int BLANK_CYC = 2;
  localparam int BLINK_H   = 1000 / (2 * 5);

  logic       clk = 1'b0;
  logic       rst, en, wr_valid;
  logic [1:0] wr_addr;
  logic [7:0] wr_char;
  logic [3:0] blink_mask;
  logic       WR_READY, FRAME_DONE;
  logic [6:0] SEG;
  logic [3:0] AN;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  seg_display_scheduler #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(2), .BLINK_HZ(5)
  ) dut (
    .CLOCK_100MHz (clk),
    .RESET        (rst),
    .ENABLE       (en),
    .WR_VALID     (wr_valid),
    .WR_READY     (WR_READY),
    .WR_ADDR      (wr_addr),
    .WR_CHAR      (wr_char),
    .BLINK_MASK   (blink_mask),
    .SEG          (SEG),
    .AN           (AN),
    .FRAME_DONE   (FRAME_DONE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endfunction

  // Glyphs described by which of segments a..g are lit.
  function automatic logic [6:0] lit(input string s);
    logic [6:0] g;
    g = 7'h7F;
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b0;
    return g;
  endfunction

  function automatic logic [6:0] glyph(input logic [7:0] c);
    case (c)
      "0": return lit("abcdef");
      "1": return lit("bc");
      "2": return lit("abdeg");
      "3": return lit("abcdg");
      "4": return lit("bcfg");
      "5": return lit("acdfg");
      "6": return lit("acdefg");
      "7": return lit("abc");
      "8": return lit("abcdefg");
      "9": return lit("abcdfg");
      "c": return lit("deg");
      "l": return lit("ef");
      "u": return lit("cde");
      "r": return lit("eg");
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: scan position is simply edges elapsed since enable.
  logic [7:0] m_shadow [4];
  logic [7:0] m_active [4];
  bit m_scan, m_dirty, m_alive;
  int m_k, m_n;

  function automatic bit frame_end(input bit scan, input int k);
    return scan && (k % DIGIT_CYC == DIGIT_CYC - 1) && ((k / DIGIT_CYC) % 4 == 3);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 8'h20;
        m_active[i] = 8'h20;
      end
      m_scan = 0; m_dirty = 0; m_alive = 0; m_k = 0; m_n = 0;
      e = '{an: 4'hF, seg: 7'h7F, fd: 1'b0, rdy: 1'b0};
    end else begin
      int  pos, dig;
      bit  commit, rdy, blink_on;
      pos      = m_k % DIGIT_CYC;
      dig      = (m_k / DIGIT_CYC) % 4;
      commit   = m_dirty && (!m_scan || frame_end(m_scan, m_k));
      rdy      = m_alive && !commit;
      blink_on = ((m_n / BLINK_H) % 2) == 0;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      if (en && m_scan && pos >= BLANK_CYC) begin
        e.seg = glyph(m_active[dig]);
        if (blink_on || !blink_mask[dig]) e.an[dig] = 1'b0;
      end
      if (commit) begin
        m_active = m_shadow;
        m_dirty  = 0;
      end
      if (wr_valid && rdy) begin
        m_shadow[wr_addr] = wr_char;
        m_dirty = 1;
      end
      if (!en) begin
        m_scan = 0; m_k = 0;
      end else if (!m_scan) begin
        m_scan = 1; m_k = 0;
      end else begin
        m_k++;
      end
      m_n++;
      m_alive = 1;
      e.fd  = frame_end(m_scan, m_k);
      e.rdy = !(m_dirty && (!m_scan || e.fd));
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("AN", {4'h0, AN}, {4'h0, e.an});
      chk("SEG", {1'b0, SEG}, {1'b0, e.seg});
      chk("FRAME_DONE", {7'h0, FRAME_DONE}, {7'h0, e.fd});
      chk("WR_READY", {7'h0, WR_READY}, {7'h0, e.rdy});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] c);
    bit acc, done;
    done = 0;
    wr_valid = 1'b1; wr_addr = a; wr_char = c;
    for (int w = 0; w < 200 && !done; w++) begin
      acc = WR_READY;
      step(1);
      if (acc) done = 1;
    end
    wr_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL write_timeout cyc=%0d actual=no_accept required=accept", cyc);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input bit match_off);
    bit hit;
    hit = 0;
    for (int w = 0; w < 200 && !hit; w++) begin
      if (match_off ? (AN != 4'hF) : (AN == target)) hit = 1;
      else step(1);
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_an cyc=%0d actual=%h required=%h", cyc, AN, target);
    end
  endtask

  logic [7:0] pool [14];

  initial begin
    pool = '{"0","1","2","3","4","5","6","7","8","9","c","l","u","r"};
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_addr = 2'd0; wr_char = 8'h00; blink_mask = 4'h0;
    step(3);
    rst = 1'b0;
    step(2);

    // Blank frame scan
    en = 1'b1;
    step(50);

    // Load "rulc" while idle, then scan it
    en = 1'b0;
    step(3);
    do_write(2'd0, "c");
    do_write(2'd1, "l");
    do_write(2'd2, "u");
    do_write(2'd3, "r");
    step(2);
    en = 1'b1;
    step(45);

    // Mid-frame update waits for the frame boundary
    do_write(2'd1, "5");
    step(60);

    // Continuous writes straddling a commit slot
    for (int i = 0; i < 50; i++)
      do_write(2'($urandom_range(0, 3)), pool[$urandom_range(0, 13)]);
    step(45);

    // Blink digit 0
    blink_mask = 4'b0001;
    step(250);
    blink_mask = 4'h0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) step($urandom_range(1, 5));
      else if (r < 88)
        do_write(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 13)]);
      else if (r < 94) blink_mask = 4'($urandom_range(0, 15));
      else begin
        en = 1'b0;
        step($urandom_range(1, 4));
        en = 1'b1;
      end
    end
    blink_mask = 4'h0;
    en = 1'b1;
    step(5);

    // Reset during digit-2 drive
    wait_an(4'hB, 0);
    rst = 1'b1;
    #1;
    chk("rst_now_AN", {4'h0, AN}, 8'h0F);
    chk("rst_now_SEG", {1'b0, SEG}, 8'h7F);
    chk("rst_now_RDY", {7'h0, WR_READY}, 8'h00);
    step(2);
    rst = 1'b0;
    step(45);

    // Drop enable during drive, then restart
    do_write(2'd2, "8");
    step(40);
    wait_an(4'hF, 1);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
